// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter.
// Holds the arbiter state encoding and the owner-index width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int calc_ow(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set req bit at or after ptr, cyclically.
// Purely combinational rotate-and-priority-encode.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  int j;

  // scan from farthest to nearest so the nearest hit wins
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter in front of a FIFO write port.
// Winner keeps the port for up to BURST_LEN beats; never writes when full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_LEN  = 2,
  localparam int OW         = calc_ow(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  input  logic                          fifo_full,
  output logic [OW-1:0]                 owner,
  output logic                          burst_active
);

  localparam int CW = $clog2(BURST_LEN + 1);

  arb_state_e    state_q, state_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  logic          pick_valid;
  logic [OW-1:0] pick_idx;
  logic [OW-1:0] pick_nxt;
  logic [OW-1:0] own_nxt;
  logic [CW-1:0] cnt_inc;
  logic [NUM_REQ-1:0] gnt_c;

  rr_pick #(
    .N (NUM_REQ),
    .W (OW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // successor indices, wrapping at NUM_REQ-1
  always_comb begin
    pick_nxt = (pick_idx == OW'(NUM_REQ - 1))
             ? '0 : pick_idx + OW'(1);
    own_nxt  = (owner_q == OW'(NUM_REQ - 1))
             ? '0 : owner_q + OW'(1);
    cnt_inc  = burst_cnt_q + CW'(1);
  end

  // next-state, grant and round-robin pointer update
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt_c       = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid && !fifo_full) begin
          gnt_c       = NUM_REQ'(1) << pick_idx;
          owner_d     = pick_idx;
          burst_cnt_d = CW'(1);
          if (BURST_LEN == 1) rr_ptr_d = pick_nxt;
          else                state_d  = BURST;
        end
      end
      BURST: begin
        if (req[owner_q]) begin
          if (!fifo_full) begin
            gnt_c       = NUM_REQ'(1) << owner_q;
            burst_cnt_d = cnt_inc;
            if (cnt_inc == CW'(BURST_LEN)) begin
              rr_ptr_d = own_nxt;
              state_d  = IDLE;
            end
          end
        end else begin
          rr_ptr_d = own_nxt;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // grant mux onto the FIFO write port, silenced during reset
  always_comb begin
    gnt         = rst_n ? gnt_c : '0;
    fifo_wr_en  = |gnt;
    fifo_w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) fifo_w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign owner        = owner_q;
  assign burst_active = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (4 requesters, 8-bit, burst 2).
// Expected per-cycle outputs go through a scoreboard queue.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b1111;
  logic [31:0] req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [3:0]  gnt;
  logic        fifo_wr_en;
  logic [7:0]  fifo_w_data;
  logic        fifo_full = 1'b0;
  logic [1:0]  owner;
  logic        burst_active;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] g;
    logic       we;
    logic [7:0] d;
    logic [1:0] o;
    logic       ba;
  } exp_t;

  exp_t sb[$];

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .BURST_LEN  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_w_data  (fifo_w_data),
    .fifo_full    (fifo_full),
    .owner        (owner),
    .burst_active (burst_active)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dat_of(input logic [3:0] g);
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) d = 8'hA0 + 8'(i);
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input string tag, input logic rs,
                     input logic [3:0] r, input logic f,
                     input logic [3:0] eg, input logic [1:0] eo,
                     input logic eb);
    exp_t e;
    @(negedge clk);
    rst_n     = rs;
    req       = r;
    fifo_full = f;
    e.g  = eg;
    e.we = (eg != 4'b0000);
    e.d  = dat_of(eg);
    e.o  = eo;
    e.ba = eb;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({tag, ".gnt"}, {4'h0, gnt}, {4'h0, e.g});
    chk({tag, ".wr_en"}, {7'h0, fifo_wr_en}, {7'h0, e.we});
    chk({tag, ".data"}, fifo_w_data, e.d);
    chk({tag, ".owner"}, {6'h0, owner}, {6'h0, e.o});
    chk({tag, ".ba"}, {7'h0, burst_active}, {7'h0, e.ba});
  endtask

  initial begin
    cyc("rst0", 0, 4'b1111, 0, 4'b0000, 2'd0, 0);
    cyc("rst1", 0, 4'b1111, 0, 4'b0000, 2'd0, 0);
    // all requesters: 0,0,1,1,2,2,3,3,0
    cyc("rr0a", 1, 4'b1111, 0, 4'b0001, 2'd0, 0);
    cyc("rr0b", 1, 4'b1111, 0, 4'b0001, 2'd0, 1);
    cyc("rr1a", 1, 4'b1111, 0, 4'b0010, 2'd0, 0);
    cyc("rr1b", 1, 4'b1111, 0, 4'b0010, 2'd1, 1);
    cyc("rr2a", 1, 4'b1111, 0, 4'b0100, 2'd1, 0);
    cyc("rr2b", 1, 4'b1111, 0, 4'b0100, 2'd2, 1);
    cyc("rr3a", 1, 4'b1111, 0, 4'b1000, 2'd2, 0);
    cyc("rr3b", 1, 4'b1111, 0, 4'b1000, 2'd3, 1);
    cyc("rr0c", 1, 4'b1111, 0, 4'b0001, 2'd3, 0);
    // owner 0 drops mid-burst: one bubble
    cyc("drop0", 1, 4'b0100, 0, 4'b0000, 2'd0, 1);
    // sole requester 2 wins back-to-back
    cyc("solo0", 1, 4'b0100, 0, 4'b0100, 2'd0, 0);
    cyc("solo1", 1, 4'b0100, 0, 4'b0100, 2'd2, 1);
    cyc("solo2", 1, 4'b0100, 0, 4'b0100, 2'd2, 0);
    cyc("solo3", 1, 4'b0100, 0, 4'b0100, 2'd2, 1);
    // full stall inside a burst
    cyc("fs0", 1, 4'b0011, 0, 4'b0001, 2'd2, 0);
    cyc("fs1", 1, 4'b0011, 1, 4'b0000, 2'd0, 1);
    cyc("fs2", 1, 4'b0011, 1, 4'b0000, 2'd0, 1);
    cyc("fs3", 1, 4'b0011, 1, 4'b0000, 2'd0, 1);
    cyc("fs4", 1, 4'b0011, 0, 4'b0001, 2'd0, 1);
    cyc("fs5", 1, 4'b0011, 0, 4'b0010, 2'd0, 0);
    cyc("fs6", 1, 4'b0011, 0, 4'b0010, 2'd1, 1);
    // early end after one beat, then next requester
    cyc("ee0", 1, 4'b0011, 0, 4'b0001, 2'd1, 0);
    cyc("ee1", 1, 4'b0010, 0, 4'b0000, 2'd0, 1);
    cyc("ee2", 1, 4'b0010, 0, 4'b0010, 2'd0, 0);
    // reach owner 2 mid-burst
    cyc("mb0", 1, 4'b0100, 0, 4'b0000, 2'd1, 1);
    cyc("mb1", 1, 4'b0100, 0, 4'b0100, 2'd1, 0);
    // reset mid-burst, restart from index 0
    cyc("mrst0", 0, 4'b1111, 0, 4'b0000, 2'd0, 0);
    cyc("mrst1", 0, 4'b1111, 0, 4'b0000, 2'd0, 0);
    cyc("mrst2", 1, 4'b1111, 0, 4'b0001, 2'd0, 0);
    cyc("mrst3", 1, 4'b1111, 0, 4'b0001, 2'd0, 1);
    cyc("mrst4", 1, 4'b1111, 0, 4'b0010, 2'd0, 0);
    // full from reset: never grants until full drops
    cyc("ff0", 0, 4'b1111, 1, 4'b0000, 2'd0, 0);
    cyc("ff1", 1, 4'b1111, 1, 4'b0000, 2'd0, 0);
    cyc("ff2", 1, 4'b1111, 1, 4'b0000, 2'd0, 0);
    cyc("ff3", 1, 4'b1111, 1, 4'b0000, 2'd0, 0);
    cyc("ff4", 1, 4'b1111, 0, 4'b0001, 2'd0, 0);
    cyc("ff5", 1, 4'b1111, 0, 4'b0001, 2'd0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that lets NUM_REQ producers share one write port of a FIFO (counter-based, shift or wrap-around flavour).
- A requester that wins arbitration keeps the port for a burst of up to BURST_LEN accepted beats. The burst ends early if that requester stops requesting.
- The arbiter drives the FIFO's wr_en/w_data directly and obeys its full flag. It never issues a write into a full FIFO.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2; need not be a power of two.
- DATA_WIDTH, 8, width of each requester's data word and of the FIFO word.
- BURST_LEN, 2, maximum consecutive accepted beats per ownership; must be >= 1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request; req[i] means req_data slice i is valid.
- req_data  input  NUM_REQ*DATA_WIDTH  flattened data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_REQ  one-hot or zero, combinational; gnt[i]=1 means requester i's word is written at this clock edge.
- fifo_wr_en  output  1  combinational write strobe to the FIFO; equals |gnt.
- fifo_w_data  output  DATA_WIDTH  combinational; the granted requester's slice, or 0 when there is no grant.
- fifo_full  input  1  full flag from the FIFO.
- owner  output  OW=max(1,$clog2(NUM_REQ))  registered index of the current or last burst owner.
- burst_active  output  1  registered; 1 while in state BURST.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, burst_active=0.
- While rst_n=0: gnt, fifo_wr_en and fifo_w_data are forced to 0.
- rr_ptr (OW bits) holds the highest-priority index. Pick rule: the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … cyclically modulo NUM_REQ.
- The counter burst_cnt is $clog2(BURST_LEN+1) bits wide.
- State IDLE:
  - If any req and !fifo_full: grant the picked index p in the same cycle; owner<=p; burst_cnt<=1.
  - On that grant, if BURST_LEN==1: rr_ptr<=(p+1)%NUM_REQ and stay in IDLE. Otherwise go to BURST.
  - If fifo_full, or no req: no grant, no state change.
- State BURST (owner fixed):
  - req[owner] && !fifo_full: grant owner; burst_cnt<=burst_cnt+1. If burst_cnt+1==BURST_LEN: rr_ptr<=(owner+1)%NUM_REQ and go to IDLE.
  - req[owner] && fifo_full: stall. No grant; burst_cnt, owner and state hold.
  - !req[owner]: no grant this cycle (one bubble); rr_ptr<=(owner+1)%NUM_REQ; go to IDLE. Other requesters are not granted in this cycle.
- Latency: a beat is accepted in the same cycle req is seen; no pipeline registers sit on the data path.
- Back-to-back bursts: the final beat of a burst and the first beat of the next burst occur in consecutive cycles (no bubble). This also holds when the same sole requester wins again.
- A requester must hold req and its data stable until granted; the arbiter does not buffer data.
- burst_active mirrors (state==BURST) from the register.
- Reset asserted mid-burst: the burst is discarded immediately; on release, arbitration restarts from index 0.

Decomposition:
- Package fifo_arb_pkg holds:
  - the enum arb_state_e {IDLE, BURST};
  - a function computing OW from NUM_REQ.
- Sub-module rr_pick: purely combinational; inputs req and ptr, outputs valid and idx (rotate-and-priority-encode). It is instantiated once in the IDLE path.

Test Plan (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=2 unless stated; req_data slice i = 8'hA0+i):
1. req=4'b1111 held, fifo_full=0 → gnt sequence 0,0,1,1,2,2,3,3,0,… every cycle; fifo_w_data A0,A0,A1,A1,A2,A2,A3,A3; no bubbles.
2. req=4'b0100 held → gnt[2]=1 every cycle; owner=2; burst_active alternates 0,1 (IDLE→BURST per burst).
3. req=4'b0011; fifo_full=1 in the cycle after the first grant to 0, held 3 cycles → gnt=0 and fifo_wr_en=0 for 3 cycles, owner=0, burst_active=1. Then full drops → one more gnt[0], then gnt[1].
4. BURST_LEN=4; req=4'b0011; req[0] drops after 1 beat → next cycle gnt=0 (bubble), rr_ptr=1. The following cycle gnt[1]=1, fifo_w_data=A1.
5. req=4'b1111, fifo_full=1 from reset → no grant ever. Release full → first grant is index 0.
6. Mid-burst with owner=2, assert rst_n=0 for 2 cycles → gnt=0 and burst_active=0 immediately. After release with req=4'b1111 → gnt[0] first.
